// File: rtl/multicycle_control.sv
// Moore control FSM sequencing a multi-cycle MIPS datapath (R-type, lw, sw, beq, bne, j, addi, andi).
// Optional macro MULTICYCLE_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond_beq,
  output logic               pcwritecond_bne,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsource,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_RWB    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_IMMEX  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_IMMWB  = STATE_W'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic               w_mem_go;
  logic               w_legal;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign w_mem_go = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_go           = 1'b1;
`endif

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_LW, OP_SW: w_legal = 1'b1;
      default:                        w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_RTYPE:         w_next = S_EXEC;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          OP_ADDI, OP_ANDI: w_next = S_IMMEX;
          default:          w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      w_next = S_MEMRD;
        else if (opcode == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_FETCH;
      end
      S_MEMRD:  w_next = w_mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = w_mem_go ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_IMMEX:  w_next = S_IMMWB;
      S_IMMWB:  w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held, so FETCH strobes never leak during reset.
  always_comb begin
    pcwrite         = 1'b0;
    pcwritecond_beq = 1'b0;
    pcwritecond_bne = 1'b0;
    iord            = 1'b0;
    memread         = 1'b0;
    memwrite        = 1'b0;
    irwrite         = 1'b0;
    memtoreg        = 1'b0;
    regdst          = 1'b0;
    regwrite        = 1'b0;
    alusrca         = 1'b0;
    alusrcb         = 2'b00;
    aluop           = 2'b00;
    pcsource        = 2'b00;
    instr_done      = 1'b0;
    illegal_op      = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = w_mem_go;
          pcwrite = w_mem_go;
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          illegal_op = !w_legal;
          instr_done = !w_legal;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          memwrite   = 1'b1;
          iord       = 1'b1;
          instr_done = w_mem_go;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_RWB: begin
          regwrite   = 1'b1;
          regdst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alusrca         = 1'b1;
          aluop           = 2'b01;
          pcsource        = 2'b01;
          instr_done      = 1'b1;
          pcwritecond_beq = (opcode == OP_BEQ);
          pcwritecond_bne = (opcode == OP_BNE);
        end
        S_JUMP: begin
          pcwrite    = 1'b1;
          pcsource   = 2'b10;
          instr_done = 1'b1;
        end
        S_IMMEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
        end
        S_IMMWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-path model plus directed literal checks.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcwrite, pcwc_beq, pcwc_bne, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource;
    logic       instr_done, illegal_op;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pcwrite, pcwritecond_beq, pcwritecond_bne, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, instr_done, illegal_op;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;

  int   total = 0;
  int   bad   = 0;
  logic chk_en = 1'b1;
  ctl_t dut_ctl;
  int   tr_state [8];
  ctl_t tr_ctl [8];

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond_beq(pcwritecond_beq), .pcwritecond_bne(pcwritecond_bne),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign dut_ctl = {pcwrite, pcwritecond_beq, pcwritecond_bne, iord, memread, memwrite, irwrite,
                    memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
                    instr_done, illegal_op};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each opcode walks a fixed list of states starting at FETCH.
  function automatic int path_len(input logic [5:0] op);
    case (op)
      6'b100011:            return 5;
      6'b101011, 6'b000000,
      6'b001000, 6'b001100: return 4;
      6'b000100, 6'b000101,
      6'b000010:            return 3;
      default:              return 2;
    endcase
  endfunction

  function automatic int path_at(input logic [5:0] op, input int k);
    int p [5];
    case (op)
      6'b100011:            p = '{0, 1, 2, 3, 4};
      6'b101011:            p = '{0, 1, 2, 5, 0};
      6'b000000:            p = '{0, 1, 6, 7, 0};
      6'b001000, 6'b001100: p = '{0, 1, 10, 11, 0};
      6'b000100, 6'b000101: p = '{0, 1, 8, 0, 0};
      6'b000010:            p = '{0, 1, 9, 0, 0};
      default:              p = '{0, 1, 0, 0, 0};
    endcase
    return p[k];
  endfunction

  function automatic ctl_t exp_ctl(input int st, input logic [5:0] op);
    ctl_t c = '0;
    case (st)
      0:  begin c.memread = 1; c.irwrite = 1; c.pcwrite = 1; c.alusrcb = 2'b01; end
      1:  begin c.alusrcb = 2'b11; c.illegal_op = (path_len(op) == 2); c.instr_done = (path_len(op) == 2); end
      2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      3:  begin c.memread = 1; c.iord = 1; end
      4:  begin c.regwrite = 1; c.memtoreg = 1; c.instr_done = 1; end
      5:  begin c.memwrite = 1; c.iord = 1; c.instr_done = 1; end
      6:  begin c.alusrca = 1; c.aluop = 2'b10; end
      7:  begin c.regwrite = 1; c.regdst = 1; c.instr_done = 1; end
      8:  begin
            c.alusrca = 1; c.aluop = 2'b01; c.pcsource = 2'b01; c.instr_done = 1;
            c.pcwc_beq = (op == 6'b000100); c.pcwc_bne = (op == 6'b000101);
          end
      9:  begin c.pcwrite = 1; c.pcsource = 2'b10; c.instr_done = 1; end
      10: begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = (op == 6'b001100) ? 2'b11 : 2'b00; end
      11: begin c.regwrite = 1; c.instr_done = 1; end
      default: ;
    endcase
    return c;
  endfunction

  logic [5:0] mop = 6'd0;
  int         mk  = 0;
  int         exp_state;
  assign exp_state = (mk == 0) ? 0 : path_at(mop, mk);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mk <= 0;
    end else if (mk == 0) begin
      mop <= opcode;
      mk  <= 1;
    end else if (mk + 1 < path_len(mop)) begin
      mk <= mk + 1;
    end else begin
      mk <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("model_state", 32'(state), 32'(exp_state));
      chk("model_ctl", 32'(dut_ctl), 32'(exp_ctl(exp_state, mop)));
    end
  end

  // Called just after a rising edge with the DUT in FETCH; returns the same way.
  task automatic run_instr(input string nm, input logic [5:0] op, input int n);
    int ndone = 0;
    opcode = op;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_state[i] = int'(state);
      tr_ctl[i]   = dut_ctl;
      if (dut_ctl.instr_done) ndone++;
      @(posedge clk);
    end
    #1;
    chk({nm, "_back_to_fetch"}, 32'(state), 32'd0);
    chk({nm, "_done_count"}, 32'(ndone), 32'd1);
    chk({nm, "_done_last"}, 32'(tr_ctl[n-1].instr_done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreg;
    #3;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctl", 32'(dut_ctl), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    run_instr("lw", 6'b100011, 5);
    nreg = 0;
    for (int i = 0; i < 5; i++) begin
      chk("lw_state", 32'(tr_state[i]), 32'(i));
      if (tr_ctl[i].regwrite) nreg++;
    end
    chk("lw_regwrite_cycles", 32'(nreg), 32'd1);
    chk("lw_wb_regwrite", 32'(tr_ctl[4].regwrite), 32'd1);
    chk("lw_wb_memtoreg", 32'(tr_ctl[4].memtoreg), 32'd1);

    run_instr("bne", 6'b000101, 3);
    chk("bne_s2", 32'(tr_state[2]), 32'd8);
    chk("bne_pcwc_bne", 32'(tr_ctl[2].pcwc_bne), 32'd1);
    chk("bne_pcwc_beq", 32'(tr_ctl[2].pcwc_beq), 32'd0);
    chk("bne_aluop", 32'(tr_ctl[2].aluop), 32'd1);
    chk("bne_pcsource", 32'(tr_ctl[2].pcsource), 32'd1);

    run_instr("andi", 6'b001100, 4);
    chk("andi_s2", 32'(tr_state[2]), 32'd10);
    chk("andi_s3", 32'(tr_state[3]), 32'd11);
    chk("andi_aluop", 32'(tr_ctl[2].aluop), 32'd3);
    chk("andi_regwrite", 32'(tr_ctl[3].regwrite), 32'd1);
    chk("andi_regdst", 32'(tr_ctl[3].regdst), 32'd0);

    run_instr("illegal", 6'b111111, 2);
    chk("ill_s1", 32'(tr_state[1]), 32'd1);
    chk("ill_flag", 32'(tr_ctl[1].illegal_op), 32'd1);
    chk("ill_writes", 32'(tr_ctl[0].regwrite | tr_ctl[0].memwrite | tr_ctl[1].regwrite | tr_ctl[1].memwrite), 32'd0);

    run_instr("sw", 6'b101011, 4);
    chk("sw_s3", 32'(tr_state[3]), 32'd5);
    run_instr("rtype", 6'b000000, 4);
    chk("rtype_regdst", 32'(tr_ctl[3].regdst), 32'd1);
    run_instr("addi", 6'b001000, 4);
    chk("addi_aluop", 32'(tr_ctl[2].aluop), 32'd0);
    run_instr("beq", 6'b000100, 3);
    chk("beq_pcwc_beq", 32'(tr_ctl[2].pcwc_beq), 32'd1);
    run_instr("j", 6'b000010, 3);
    chk("j_pcsource", 32'(tr_ctl[2].pcsource), 32'd2);

    // Reset dropped in the middle of an R-type instruction.
    opcode = 6'b000000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_exec_state", 32'(state), 32'd6);
    rst = 1'b0;
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_ctl", 32'(dut_ctl), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_instr("post_reset", 6'b000000, 4);
    chk("post_reset_memread", 32'(tr_ctl[0].memread), 32'd1);
    chk("post_reset_irwrite", 32'(tr_ctl[0].irwrite), 32'd1);
    chk("post_reset_pcwrite", 32'(tr_ctl[0].pcwrite), 32'd1);
    chk("post_reset_alusrcb", 32'(tr_ctl[0].alusrcb), 32'd1);

`ifdef MULTICYCLE_MEM_WAIT_EN
    chk_en = 1'b0;
    opcode = 6'b101011;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      @(negedge clk);
      chk("wait_state", 32'(state), 32'd5);
      chk("wait_memwrite", 32'(memwrite), 32'd1);
      chk("wait_done", 32'(instr_done), 32'(i == 3));
      @(posedge clk);
      #1;
    end
    chk("wait_to_fetch", 32'(state), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences a multi-cycle MIPS datapath: one shared memory, IR, A/B/ALUOut/MDR latches, single ALU.
- Replaces the single-cycle combinational control decoder; sits beside the datapath and drives every mux select and write enable from its current state plus the IR opcode.
- Supported ops: R-type, lw, sw, beq, bne, j, addi, andi.

Parameters:
- STATE_W, 4, width of the state register and `state` debug port.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from the DECODE cycle onward.
- mem_ready  in  1  memory-done handshake; used only with MEM_WAIT_EN.
- pcwrite  out  1  unconditional PC write.
- pcwritecond_beq  out  1  PC write if ALU zero.
- pcwritecond_bne  out  1  PC write if ALU not-zero.
- iord  out  1  memory address: 0=PC, 1=ALUOut.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  IR load.
- memtoreg  out  1  register write data: 0=ALUOut, 1=MDR.
- regdst  out  1  write register: 0=rt, 1=rd.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A input: 0=PC, 1=A.
- alusrcb  out  2  ALU B input: 00=B, 01=4, 10=sext imm, 11=sext imm<<2.
- aluop  out  2  00 add, 01 sub, 10 funct, 11 and.
- pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump address.
- instr_done  out  1  high in the last cycle of each instruction.
- illegal_op  out  1  high in DECODE when the opcode is unsupported.
- state  out  STATE_W  current state, for debug.

Behaviour:
- Reset: rst low asynchronously forces state=FETCH(0). While rst is low, every output is 0, including state.
  - The first rising edge after rst goes high completes FETCH.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IMMEX 10, IMMWB 11.
- Unused encodings transition to FETCH on the next edge, with all outputs 0.
- Outputs are pure functions of state (and opcode in BRANCH/IMMEX); unlisted outputs are 0.
  - FETCH: memread, irwrite, pcwrite, alusrcb=01, aluop=00, pcsource=00 → DECODE.
  - DECODE: alusrcb=11, aluop=00.
    - Next state by opcode: 100011/101011 → MEMADR; 000000 → EXEC; 000100/000101 → BRANCH; 000010 → JUMP; 001000/001100 → IMMEX; anything else → FETCH with illegal_op=1 and instr_done=1.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00 → MEMRD if lw, MEMWR if sw.
  - MEMRD: memread, iord=1 → MEMWB.
  - MEMWB: regwrite, memtoreg=1, regdst=0, instr_done → FETCH.
  - MEMWR: memwrite, iord=1, instr_done → FETCH.
  - EXEC: alusrca=1, alusrcb=00, aluop=10 → RWB.
  - RWB: regwrite, regdst=1, memtoreg=0, instr_done → FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsource=01, instr_done → FETCH.
    - pcwritecond_beq=1 if opcode=000100; pcwritecond_bne=1 if opcode=000101.
  - JUMP: pcwrite, pcsource=10, instr_done → FETCH.
  - IMMEX: alusrca=1, alusrcb=10 → IMMWB. aluop=00 for addi, 11 for andi.
  - IMMWB: regwrite, regdst=0, memtoreg=0, instr_done → FETCH.
- Cycles per instruction: lw 5; sw, R-type and addi/andi 4; beq/bne and j 3; illegal 2.
- Reset asserted mid-instruction: the instruction is abandoned immediately. No partial writes are issued after rst falls.

Optional Feature:
- Macro: MULTICYCLE_MEM_WAIT_EN.
- Defined: FETCH, MEMRD and MEMWR hold state while mem_ready=0.
  - Addressing outputs and memread/memwrite stay asserted throughout the hold.
  - pcwrite, irwrite and instr_done (MEMWR) are asserted only in the cycle where mem_ready=1.
  - The state advances on the edge ending that cycle.
- Undefined: mem_ready is ignored; every state lasts exactly one cycle.

Test Plan:
- rst=0 mid-EXEC, all outputs checked → state=0, all outputs 0 asynchronously; after release, FETCH has memread=irwrite=pcwrite=1, alusrcb=01.
- opcode=100011 (lw) → states 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; instr_done pulses once; 5 cycles total.
- opcode=000101 (bne) → states 0,1,8; in state 8, pcwritecond_bne=1, pcwritecond_beq=0, aluop=01, pcsource=01.
- opcode=001100 (andi) → states 0,1,10,11; aluop=11 in state 10; regwrite=1, regdst=0 in state 11.
- opcode=111111 → states 0,1,0; illegal_op=1 and instr_done=1 in DECODE; no regwrite or memwrite at any point.
- With MULTICYCLE_MEM_WAIT_EN, sw with mem_ready low for 3 cycles in MEMWR → state holds 5 for 4 cycles with memwrite=1 throughout; instr_done high only in the final cycle; then FETCH.
